mem_bus_master: RTL
===================

Name: mem_bus_master

Overview:
- Initiator side of the shared memory bus. Converts CPU-core transfer requests into T1/T2/T3 bus cycles that drive addr_bus, en and en_read, and the tri-state data_bus.
- Supports single-beat and auto-incrementing burst reads and writes, with configurable wait states.
- Sits between the 8085 core's execution/fetch logic and the memory block.

Parameters:
DATA_WIDTH, 8, data bus / data port width
ADDR_WIDTH, 16, address width
LEN_WIDTH, 4, burst length field width; beats = len+1 (1..16)
WAIT_STATES, 0, extra T2 cycles inserted before data transfer (0..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  transfer request from core
req_ready  out  1  high only in IDLE; request accepted on req&req_ready
wr  in  1  1=write burst, 0=read burst (sampled at accept)
addr  in  ADDR_WIDTH  start address (sampled at accept)
len  in  LEN_WIDTH  beats minus one (sampled at accept)
wdata  in  DATA_WIDTH  write beat data
wvalid  in  1  wdata valid
wready  out  1  high in T1 of a write beat; beat data taken on wvalid&wready
rdata  out  DATA_WIDTH  captured read beat
rvalid  out  1  one-cycle pulse per read beat, no backpressure
done  out  1  one-cycle pulse in T3 of the final beat
busy  out  1  high whenever not IDLE
addr_bus  out  ADDR_WIDTH  memory address
en  out  1  memory enable
en_read  out  1  1 = memory samples data_bus (write), 0 = memory drives data_bus (read)
data_bus  inout  DATA_WIDTH  shared tri-state data

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - en=0, en_read=0, data_bus=Z, addr_bus=0, rdata=0.
  - rvalid=0, done=0, wready=0, busy=0, req_ready=1.
  - Beat and wait counters clear.
  - Reset asserted mid-burst abandons the burst. No partial done/rvalid is issued afterwards.
- States: IDLE, T1, T2, T3.
- IDLE:
  - On req&req_ready, latch addr/wr/len into cur_addr/wr_q/beats_left=len and go to T1.
  - req while not IDLE is ignored.
- T1:
  - addr_bus=cur_addr, en=0, en_read=wr_q, data_bus=Z.
  - Read: always advance to T2 next cycle.
  - Write: wready=1. On wvalid, latch wdata into wdata_q and advance to T2. Otherwise remain in T1 (stall, unbounded).
- T2:
  - en=1, addr_bus held.
  - Write: en_read=1, data_bus=wdata_q.
  - Read: en_read=0, data_bus=Z.
  - Lasts 1+WAIT_STATES cycles (wait counter).
  - At the rising edge ending the last T2 cycle:
    - Write: the memory stores the beat.
    - Read: the master captures data_bus into rdata.
- T3 (turnaround, exactly 1 cycle):
  - en=0, en_read=0, data_bus=Z.
  - Read: rvalid=1 with rdata stable.
  - If beats_left==0: done=1, next state IDLE.
  - Else: beats_left-1, cur_addr+1 modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000), next state T1.
- Contention rule: data_bus is driven only when en=1 and en_read=1, i.e. T2 of a write. In every other state the master outputs Z.
- All control outputs are registered or decoded from the registered state only. There are no combinational paths from req/wvalid to bus pins.
- Latency, WAIT_STATES=0:
  - Single read: accept edge → T1 → T2 → T3 (rvalid, done) → IDLE. That is 3 cycles busy, then req_ready returns.
  - N-beat burst with no stalls: 3N cycles.
- done and the final rvalid coincide in the same cycle.

Test Plan:
- Write beat: addr=0x0005, wdata=0xA5, len=0. Then a read of 0x0005 → en=1/en_read=1 with data_bus=0xA5 for exactly 1 cycle. The read then returns rvalid with rdata=0xA5 in its T3, done in the same cycle, and busy 3 cycles per transfer.
- Burst read: addr=0x001C, len=3, memory preloaded 0x11,0x22,0x33,0x44 → four rvalid pulses 3 cycles apart carrying those values in order, with addr_bus 0x1C..0x1F. done only on the 4th pulse.
- Address wrap: burst write addr=0xFFFF, len=1, wdata 0x5A,0x6B → addr_bus 0xFFFF then 0x0000. Bytes land at those locations.
- Write stall: wvalid low for 3 cycles in T1 → state holds T1, en=0, wready=1 throughout. T2 starts the cycle after wvalid rises. The transfer still completes with the correct data.
- WAIT_STATES=2 single read → en high for 3 consecutive cycles. rdata is sampled only at the end of the third. Total busy is 5 cycles.
- Reset mid-T2 of a write, plus bus checker throughout → en, en_read and data_bus go 0/0/Z in the same cycle rst_n falls, with no done. A monitor flags any cycle where the master drives data_bus while en_read=0 (it must never fire).

Source files
------------

// File: rtl/mem_bus_master.sv
// Memory bus initiator: turns core transfer requests into T1/T2/T3 cycles on a shared tri-state bus.
// Latency: 3+WAIT_STATES cycles per beat; done pulses in T3 of the final beat.
// Backpressure: req_ready_o only in IDLE; write beats stall in T1 until wvalid_i; read beats never stall.
module mem_bus_master #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH   = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    output logic                  req_ready_o,
    input  logic                  wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] addr_bus_o,
    output logic                  en_o,
    output logic                  en_read_o,
    inout  wire  [DATA_WIDTH-1:0] data_bus_io
);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic                  wr_q, wr_d;
    logic [LEN_WIDTH-1:0]  beats_left_q, beats_left_d;
    logic [3:0]            wait_q, wait_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            wr_q         <= 1'b0;
            beats_left_q <= '0;
            wait_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            wr_q         <= wr_d;
            beats_left_q <= beats_left_d;
            wait_q       <= wait_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        wr_d         = wr_q;
        beats_left_d = beats_left_q;
        wait_d       = wait_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    cur_addr_d   = addr_i;
                    wr_d         = wr_i;
                    beats_left_d = len_i;
                    state_d      = T1;
                end
            end
            T1: begin
                if (!wr_q || wvalid_i) begin
                    if (wr_q) begin
                        wdata_d = wdata_i;
                    end
                    wait_d  = '0;
                    state_d = T2;
                end
            end
            T2: begin
                // Read data is sampled only on the edge that closes the last wait cycle.
                if (wait_q == WAIT_LAST) begin
                    if (!wr_q) begin
                        rdata_d = data_bus_io;
                    end
                    state_d = T3;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            T3: begin
                if (beats_left_q == '0) begin
                    state_d = IDLE;
                end else begin
                    beats_left_d = beats_left_q - 1'b1;
                    cur_addr_d   = cur_addr_q + 1'b1;
                    state_d      = T1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every bus-facing output decodes registered state only, so reset clears them at once.
    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign wready_o    = (state_q == T1) && wr_q;
    assign en_o        = (state_q == T2);
    assign en_read_o   = wr_q && ((state_q == T1) || (state_q == T2));
    assign addr_bus_o  = cur_addr_q;
    assign rdata_o     = rdata_q;
    assign rvalid_o    = (state_q == T3) && !wr_q;
    assign done_o      = (state_q == T3) && (beats_left_q == '0);
    assign data_bus_io = ((state_q == T2) && wr_q) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
